capture_tap_trainer: RTL and testbench

Sequencing controller for a capture flop placed behind a programmable input delay line. It drives a toggling training pattern and sweeps every delay tap. At each tap it checks the captured data against the expected pattern, then programs the centre of the widest contiguous passing window. This removes setup/hold violations on that capture path without hand-tuned wire delays. It sits beside the capture flop and delay line, and is started by system control after reset or after a clock change.

---
 rtl/capture_trainer_pkg.sv | 23 ++
 rtl/pattern_checker.sv | 82 ++++++++
 rtl/capture_tap_trainer.sv | 204 ++++++++++++++++++++
 tb/tb_capture_tap_trainer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/capture_trainer_pkg.sv
// Purpose: shared FSM encoding and timing helper for the capture tap trainer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t        - trainer FSM states
//   cycles_per_tap - cycles spent on one tap (settle + compare + evaluate)
package capture_trainer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_EVAL,
    ST_CENTER
  } state_t;

  // One tap visit: SETTLE ignored cycles, SAMPLES compare cycles, one EVAL cycle.
  function automatic int cycles_per_tap(input int settle, input int samples);
    return settle + samples + 1;
  endfunction

endpackage

// File: rtl/pattern_checker.sv
// Purpose: training-pattern source and per-tap error counter for the capture path.
// Latency: expected bit is tx_bit delayed LAT cycles; err_cnt updates one cycle after each compare.
// Backpressure: none; driven entirely by the trainer FSM's run/cmp_en/clr strobes.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   run         - toggle tx_bit every cycle while high, hold while low
//   cmp_en      - compare sample_in against the delayed pattern this cycle
//   clr         - clear the error count (wins over cmp_en)
//   sample_in   - captured data from the capture flop
//   tx_bit      - training pattern to the launch side of the delay line
//   pass        - high when no mismatch has been counted since the last clear
module pattern_checker #(
  parameter int SAMPLES = 16,
  parameter int LAT     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic cmp_en,
  input  logic clr,
  input  logic sample_in,
  output logic tx_bit,
  output logic pass
);

  localparam int ERR_W = $clog2(SAMPLES + 1);

  logic [LAT-1:0]   exp_sr;
  logic [ERR_W-1:0] err_cnt;
  logic             exp_bit;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_bit <= 1'b0;
    end else if (run) begin
      tx_bit <= ~tx_bit;
    end
  end

  // Free-running copy of the launched pattern, aligned with the capture
  // pipeline so exp_bit is what a clean capture path delivers this cycle.
  generate
    if (LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          exp_sr <= '0;
        end else begin
          exp_sr <= tx_bit;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          exp_sr <= '0;
        end else begin
          exp_sr <= {exp_sr[LAT-2:0], tx_bit};
        end
      end
    end
  endgenerate

  assign exp_bit = exp_sr[LAT-1];

  // Case inequality so an unknown or floating capture counts as an error;
  // real hardware always resolves to a level.
  assign mismatch = (sample_in !== exp_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (cmp_en && mismatch && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  assign pass = (err_cnt == '0);

endmodule

// File: rtl/capture_tap_trainer.sv
// Purpose: sweeps every delay tap with a toggling pattern and programs the centre of the widest passing window.
// Latency: 2^TAP_W*(SETTLE+SAMPLES+1)+1 cycles from start acceptance to the done pulse.
// Backpressure: none; start is honoured only when idle and not in the done cycle, otherwise dropped.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - one-cycle training request
//   tx_bit            - training pattern to the delay line launch side
//   sample_in         - capture flop output
//   tap_sel           - delay-line tap setting (sweep position, then chosen centre)
//   busy              - high while training
//   done              - one-cycle completion pulse
//   fail              - best window narrower than MIN_WIN (or empty); held until next start
//   best_lo, best_hi  - edges of the chosen window; held until next start
module capture_tap_trainer
  import capture_trainer_pkg::*;
#(
  parameter int TAP_W   = 5,
  parameter int SETTLE  = 4,
  parameter int SAMPLES = 16,
  parameter int LAT     = 2,
  parameter int MIN_WIN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             tx_bit,
  input  logic             sample_in,
  output logic [TAP_W-1:0] tap_sel,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [TAP_W-1:0] best_lo,
  output logic [TAP_W-1:0] best_hi
);

  localparam int TAP_CYCLES = cycles_per_tap(SETTLE, SAMPLES);
  localparam int CNT_W      = $clog2(TAP_CYCLES);
  // One extra bit so a window covering every tap still fits.
  localparam int LEN_W      = TAP_W + 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [TAP_W-1:0]   run_start_q, run_start_d;
  logic [LEN_W-1:0]   run_len_q, run_len_d;
  logic [TAP_W-1:0]   best_lo_q, best_lo_d;
  logic [TAP_W-1:0]   best_hi_q, best_hi_d;
  logic [LEN_W-1:0]   best_len_q, best_len_d;
  logic               fail_q, fail_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               chk_clr;
  logic               chk_cmp;
  logic               chk_pass;
  logic [TAP_W-1:0]   seg_start;
  logic [LEN_W-1:0]   seg_len;
  logic [LEN_W-1:0]   center_sum;

  pattern_checker #(
    .SAMPLES (SAMPLES),
    .LAT     (LAT)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (busy_q),
    .cmp_en    (chk_cmp),
    .clr       (chk_clr),
    .sample_in (sample_in),
    .tx_bit    (tx_bit),
    .pass      (chk_pass)
  );

  assign chk_cmp = (state_q == ST_CHECK);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tap_d       = tap_q;
    run_start_d = run_start_q;
    run_len_d   = run_len_q;
    best_lo_d   = best_lo_q;
    best_hi_d   = best_hi_q;
    best_len_d  = best_len_q;
    fail_d      = fail_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    chk_clr     = 1'b0;
    seg_start   = run_start_q;
    seg_len     = run_len_q;
    center_sum  = {1'b0, best_lo_q} + {1'b0, best_hi_q};

    case (state_q)
      ST_IDLE: begin
        // done_q marks the completion cycle; a start there is dropped.
        if (start && !done_q) begin
          state_d     = ST_SETTLE;
          cnt_d       = '0;
          tap_d       = '0;
          run_start_d = '0;
          run_len_d   = '0;
          best_lo_d   = '0;
          best_hi_d   = '0;
          best_len_d  = '0;
          fail_d      = 1'b0;
          busy_d      = 1'b1;
          chk_clr     = 1'b1;
        end
      end

      // cnt runs 0..TAP_CYCLES-1 across one tap visit; its value selects the phase.
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE + SAMPLES - 1)) begin
          state_d = ST_EVAL;
        end
      end

      ST_EVAL: begin
        cnt_d = '0;
        if (chk_pass) begin
          seg_start   = (run_len_q == '0) ? tap_q : run_start_q;
          seg_len     = run_len_q + LEN_W'(1);
          run_start_d = seg_start;
          run_len_d   = seg_len;
          // Strictly greater: on a tie the earlier (lower) window is kept.
          if (seg_len > best_len_q) begin
            best_lo_d  = seg_start;
            best_hi_d  = tap_q;
            best_len_d = seg_len;
          end
        end else begin
          run_len_d = '0;
        end

        if (tap_q != {TAP_W{1'b1}}) begin
          tap_d   = tap_q + TAP_W'(1);
          chk_clr = 1'b1;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_CENTER;
        end
      end

      ST_CENTER: begin
        // Floor of the midpoint, i.e. rounded toward best_lo.
        tap_d   = (best_len_q == '0) ? '0 : TAP_W'(center_sum >> 1);
        fail_d  = (best_len_q < LEN_W'(MIN_WIN));
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tap_q       <= '0;
      run_start_q <= '0;
      run_len_q   <= '0;
      best_lo_q   <= '0;
      best_hi_q   <= '0;
      best_len_q  <= '0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tap_q       <= tap_d;
      run_start_q <= run_start_d;
      run_len_q   <= run_len_d;
      best_lo_q   <= best_lo_d;
      best_hi_q   <= best_hi_d;
      best_len_q  <= best_len_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tap_sel = tap_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign fail    = fail_q;
  assign best_lo = best_lo_q;
  assign best_hi = best_hi_q;

endmodule

// File: tb/tb_capture_tap_trainer.sv
module tb_capture_tap_trainer;

  localparam int TAP_W   = 3;
  localparam int SETTLE  = 2;
  localparam int SAMPLES = 4;
  localparam int LAT     = 2;
  localparam int MIN_WIN = 2;
  localparam int NTAPS   = 8;
  localparam int PER_TAP = SETTLE + SAMPLES + 1;
  localparam int RUN_CYC = NTAPS * PER_TAP + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             tx_bit;
  logic             sample_in;
  logic [TAP_W-1:0] tap_sel;
  logic             busy;
  logic             done;
  logic             fail;
  logic [TAP_W-1:0] best_lo;
  logic [TAP_W-1:0] best_hi;

  // Delay line + capture flop model: clean delayed pattern at passing taps, X elsewhere.
  logic [NTAPS-1:0] pass_mask = '0;
  logic             corrupt = 1'b0;
  logic [LAT-1:0]   dl = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) dl <= {dl[LAT-2:0], tx_bit};

  assign sample_in = pass_mask[tap_sel] ? (dl[LAT-1] ^ corrupt) : 1'bx;

  capture_tap_trainer #(
    .TAP_W   (TAP_W),
    .SETTLE  (SETTLE),
    .SAMPLES (SAMPLES),
    .LAT     (LAT),
    .MIN_WIN (MIN_WIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tx_bit    (tx_bit),
    .sample_in (sample_in),
    .tap_sel   (tap_sel),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .best_lo   (best_lo),
    .best_hi   (best_hi)
  );

  typedef struct {
    logic [NTAPS-1:0] mask;
    int               ctap;   // tap with one corrupted sample, -1 for none
    int               cj;     // which compare cycle of that tap is corrupted
    int               lo;
    int               hi;
    int               tsel;
    int               f;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: try every [a,b] span, keep the first widest fully-passing one.
  task automatic ref_model(input logic [NTAPS-1:0] m, output int lo, output int hi,
                           output int tsel, output int f);
    int bw;
    bw = 0; lo = 0; hi = 0;
    for (int a = 0; a < NTAPS; a++) begin
      for (int b = a; b < NTAPS; b++) begin
        bit ok;
        ok = 1'b1;
        for (int k = a; k <= b; k++) if (!m[k]) ok = 1'b0;
        if (ok && (b - a + 1) > bw) begin
          bw = b - a + 1; lo = a; hi = b;
        end
      end
    end
    tsel = (bw == 0) ? 0 : (lo + hi) / 2;
    f    = (bw < MIN_WIN) ? 1 : 0;
  endtask

  // Cycle n is the n-th clock period after the start-accept edge.
  task automatic run_training(input logic [NTAPS-1:0] m, input int ctap, input int cj,
                              input int mid_start, input bit start_on_done, input string tag,
                              output int lo, output int hi, output int tsel, output int f);
    int n;
    int busy_n;
    bit seen;
    pass_mask = m;
    corrupt   = 1'b0;
    lo = -1; hi = -1; tsel = -1; f = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n      = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && n <= 4 * RUN_CYC) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
      end else begin
        corrupt = (ctap >= 0) && (n == ctap * PER_TAP + SETTLE + cj);
        start   = (n == mid_start);
        @(negedge clk);
        n++;
      end
    end
    corrupt = 1'b0;
    start   = 1'b0;
    check({tag, "_done_latency"}, n, RUN_CYC);
    if (seen) begin
      check({tag, "_busy_cycles"}, busy_n, RUN_CYC);
      lo = int'(best_lo); hi = int'(best_hi); tsel = int'(tap_sel); f = int'(fail);
      start = start_on_done;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_done_pulse"}, int'(done), 0);
      if (start_on_done) begin
        check({tag, "_start_on_done_ignored"}, int'(busy), 0);
        check({tag, "_result_held"}, int'(tap_sel), tsel);
      end
    end
  endtask

  initial begin
    int lo, hi, tsel, f;
    int elo, ehi, etsel, ef;
    logic [NTAPS-1:0] m, eff;
    int ctap, cj;

    vecs[0] = '{8'h3C, -1, 0, 2, 5, 3, 0};
    vecs[1] = '{8'h76, -1, 0, 4, 6, 5, 0};
    vecs[2] = '{8'h66, -1, 0, 1, 2, 1, 0};
    vecs[3] = '{8'h00, -1, 0, 0, 0, 0, 1};
    vecs[4] = '{8'hFF, -1, 0, 0, 7, 3, 0};
    vecs[5] = '{8'h40, -1, 0, 6, 6, 6, 1};
    vecs[6] = '{8'h3C,  3, SAMPLES - 1, 4, 5, 4, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tap_sel", int'(tap_sel), 0);
    check("rst_tx_bit",  int'(tx_bit), 0);
    check("rst_busy",    int'(busy), 0);
    check("rst_done",    int'(done), 0);
    check("rst_fail",    int'(fail), 0);
    check("rst_best_lo", int'(best_lo), 0);
    check("rst_best_hi", int'(best_hi), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed windows
    for (int i = 0; i < 7; i++) begin
      run_training(vecs[i].mask, vecs[i].ctap, vecs[i].cj, -1, 1'b0,
                   $sformatf("v%0d", i), lo, hi, tsel, f);
      check($sformatf("v%0d_best_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_best_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_tap_sel", i), tsel, vecs[i].tsel);
      check($sformatf("v%0d_fail", i), f, vecs[i].f);
    end

    // start pulsed mid-sweep must not restart or extend the run
    run_training(8'h3C, -1, 0, 20, 1'b0, "mid_start", lo, hi, tsel, f);
    check("mid_start_tap_sel", tsel, 3);

    // start in the done cycle must be dropped
    run_training(8'h76, -1, 0, -1, 1'b1, "start_on_done", lo, hi, tsel, f);
    check("start_on_done_tap_sel", tsel, 5);

    // Asynchronous reset mid-sweep
    pass_mask = 8'hFF;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_tap_sel", int'(tap_sel), 0);
    check("arst_tx_bit",  int'(tx_bit), 0);
    check("arst_busy",    int'(busy), 0);
    check("arst_done",    int'(done), 0);
    check("arst_fail",    int'(fail), 0);
    check("arst_best_lo", int'(best_lo), 0);
    check("arst_best_hi", int'(best_hi), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_stays_idle", int'(busy), 0);
    check("arst_tap_idle", int'(tap_sel), 0);
    run_training(8'h3C, -1, 0, -1, 1'b0, "post_rst", lo, hi, tsel, f);
    check("post_rst_tap_sel", tsel, 3);

    // Randomized masks and corruption against the reference model
    for (int r = 0; r < 16; r++) begin
      m    = NTAPS'($urandom_range(0, 255));
      ctap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NTAPS - 1)) : -1;
      cj   = int'($urandom_range(0, SAMPLES - 1));
      eff  = m;
      if (ctap >= 0) eff[ctap] = 1'b0;
      ref_model(eff, elo, ehi, etsel, ef);
      run_training(m, ctap, cj, -1, 1'b0, $sformatf("rnd%0d", r), lo, hi, tsel, f);
      check($sformatf("rnd%0d_best_lo", r), lo, elo);
      check($sformatf("rnd%0d_best_hi", r), hi, ehi);
      check($sformatf("rnd%0d_tap_sel", r), tsel, etsel);
      check($sformatf("rnd%0d_fail", r), f, ef);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
